// File: rtl/chroma_db_ctrl.sv
// Chroma deblocking sequencer: walks Cb then Cr edges of one macroblock, issuing
// pixel-buffer reads, filter BS/QP aligned to read data, and delayed write-backs.
module chroma_db_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        disable_all_i,
    input  logic        left_en_i,
    input  logic        top_en_i,
    input  logic [23:0] bs_v_i,
    input  logic [23:0] bs_h_i,
    input  logic [5:0]  qp_cb_cur_i,
    input  logic [5:0]  qp_cb_left_i,
    input  logic [5:0]  qp_cb_top_i,
    input  logic [5:0]  qp_cr_cur_i,
    input  logic [5:0]  qp_cr_left_i,
    input  logic [5:0]  qp_cr_top_i,
    output logic        rd_en,
    output logic        rd_comp,
    output logic        rd_dir,
    output logic        rd_edge,
    output logic [2:0]  rd_line,
    output logic [2:0]  pipe_bs_o,
    output logic [5:0]  pipe_qp1_o,
    output logic [5:0]  pipe_qp2_o,
    output logic        wr_en,
    output logic        wr_comp,
    output logic        wr_dir,
    output logic        wr_edge,
    output logic [2:0]  wr_line,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WR_LAT = RD_LAT + 2;
    localparam int unsigned CW     = 8;
    localparam int unsigned TW     = 7;

    typedef enum logic [3:0] {
        IDLE, CB_V, GAP1, CB_H, CR_V, GAP2, CR_H, DRAIN, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          left_q, top_q;
    logic [23:0]   bs_v_q, bs_h_q;
    logic [5:0]    qcb_cur_q, qcb_left_q, qcb_top_q;
    logic [5:0]    qcr_cur_q, qcr_left_q, qcr_top_q;

    logic          last_read;
    logic          cnt_end;
    logic [4:0]    bs_idx;
    logic [23:0]   bs_src;
    logic [2:0]    bs_sel;
    logic [5:0]    qp_cur, qp_side, qp1_sel;

    assign last_read = rd_edge && (rd_line == 3'd7);
    assign cnt_end   = (cnt == CW'(WR_LAT - 1));

    // BS field for the current read line: segment is the line pair index
    assign bs_idx = 5'({rd_edge, rd_line[2:1]}) * 5'd3;
    assign bs_src = rd_dir ? bs_h_q : bs_v_q;
    assign bs_sel = bs_src[bs_idx +: 3];

    always_comb begin
        qp_cur  = rd_comp ? qcr_cur_q : qcb_cur_q;
        qp_side = rd_comp ? (rd_dir ? qcr_top_q : qcr_left_q)
                          : (rd_dir ? qcb_top_q : qcb_left_q);
        qp1_sel = rd_edge ? qp_cur : qp_side;
    end

    // Sequencer; read tags are held at zero whenever no read is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            left_q     <= 1'b0;
            top_q      <= 1'b0;
            bs_v_q     <= '0;
            bs_h_q     <= '0;
            qcb_cur_q  <= '0;
            qcb_left_q <= '0;
            qcb_top_q  <= '0;
            qcr_cur_q  <= '0;
            qcr_left_q <= '0;
            qcr_top_q  <= '0;
            rd_en      <= 1'b0;
            rd_comp    <= 1'b0;
            rd_dir     <= 1'b0;
            rd_edge    <= 1'b0;
            rd_line    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        left_q     <= left_en_i;
                        top_q      <= top_en_i;
                        bs_v_q     <= bs_v_i;
                        bs_h_q     <= bs_h_i;
                        qcb_cur_q  <= qp_cb_cur_i;
                        qcb_left_q <= qp_cb_left_i;
                        qcb_top_q  <= qp_cb_top_i;
                        qcr_cur_q  <= qp_cr_cur_i;
                        qcr_left_q <= qp_cr_left_i;
                        qcr_top_q  <= qp_cr_top_i;
                        busy       <= 1'b1;
                        if (disable_all_i) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= CB_V;
                            rd_en   <= 1'b1;
                            rd_comp <= 1'b0;
                            rd_dir  <= 1'b0;
                            rd_edge <= ~left_en_i;
                            rd_line <= '0;
                        end
                    end
                end
                CB_V, CB_H, CR_V, CR_H: begin
                    if (!last_read) begin
                        if (rd_line == 3'd7) begin
                            rd_edge <= 1'b1;
                            rd_line <= '0;
                        end else begin
                            rd_line <= rd_line + 3'd1;
                        end
                    end else begin
                        rd_en   <= 1'b0;
                        rd_comp <= 1'b0;
                        rd_dir  <= 1'b0;
                        rd_edge <= 1'b0;
                        rd_line <= '0;
                        cnt     <= '0;
                        unique case (state)
                            CB_V: state <= GAP1;
                            CB_H: begin
                                // no dependency between Cb horizontal and Cr vertical
                                state   <= CR_V;
                                rd_en   <= 1'b1;
                                rd_comp <= 1'b1;
                                rd_edge <= ~left_q;
                            end
                            CR_V:    state <= GAP2;
                            default: state <= DRAIN;
                        endcase
                    end
                end
                GAP1, GAP2: begin
                    if (cnt_end) begin
                        state   <= (state == GAP1) ? CB_H : CR_H;
                        rd_en   <= 1'b1;
                        rd_comp <= (state == GAP2);
                        rd_dir  <= 1'b1;
                        rd_edge <= ~top_q;
                        rd_line <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Filter side-band: BS is zero between valid lines, QP holds its last value
    logic [2:0] bs_d  [RD_LAT];
    logic [5:0] qp1_d [RD_LAT];
    logic [5:0] qp2_d [RD_LAT];
    logic       vld_d [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                bs_d[i]  <= '0;
                qp1_d[i] <= '0;
                qp2_d[i] <= '0;
                vld_d[i] <= 1'b0;
            end
        end else begin
            vld_d[0] <= rd_en;
            bs_d[0]  <= rd_en ? bs_sel : 3'd0;
            if (rd_en) begin
                qp1_d[0] <= qp1_sel;
                qp2_d[0] <= qp_cur;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_d[i] <= vld_d[i-1];
                bs_d[i]  <= bs_d[i-1];
                if (vld_d[i-1]) begin
                    qp1_d[i] <= qp1_d[i-1];
                    qp2_d[i] <= qp2_d[i-1];
                end
            end
        end
    end

    assign pipe_bs_o  = bs_d[RD_LAT-1];
    assign pipe_qp1_o = qp1_d[RD_LAT-1];
    assign pipe_qp2_o = qp2_d[RD_LAT-1];

    // Write-back command is the read command delayed past the filter
    logic [WR_LAT-1:0][TW-1:0] wr_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sr <= '0;
        end else begin
            wr_sr <= {wr_sr[WR_LAT-2:0], rd_en, rd_comp, rd_dir, rd_edge, rd_line};
        end
    end

    assign {wr_en, wr_comp, wr_dir, wr_edge, wr_line} = wr_sr[WR_LAT-1];

endmodule

// File: tb/tb_chroma_db_ctrl.sv
// Bench for chroma_db_ctrl: table of macroblock configurations checked cycle by cycle
// against a schedule model on RD_LAT=1 and RD_LAT=2 instances, plus corner sequences.
module tb_chroma_db_ctrl;

    typedef struct packed {
        logic       rd_en, rd_comp, rd_dir, rd_edge;
        logic [2:0] rd_line;
        logic [2:0] bs;
        logic [5:0] q1, q2;
        logic       wr_en, wr_comp, wr_dir, wr_edge;
        logic [2:0] wr_line;
        logic       busy, done;
    } obs_t;

    typedef struct {
        logic        left, top, dis;
        logic [23:0] bsv, bsh;
        logic [5:0]  cb_cur, cb_left, cb_top, cr_cur, cr_left, cr_top;
        int          exp_reads;
        int          exp_done1;
        int          exp_done2;
    } vec_t;

    localparam int NC = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic dis = 1'b0, left = 1'b0, top = 1'b0;
    logic [23:0] bsv = '0, bsh = '0;
    logic [5:0] qcb_cur = '0, qcb_left = '0, qcb_top = '0;
    logic [5:0] qcr_cur = '0, qcr_left = '0, qcr_top = '0;

    logic a_rd_en, a_rd_comp, a_rd_dir, a_rd_edge, a_wr_en, a_wr_comp, a_wr_dir, a_wr_edge;
    logic a_busy, a_done;
    logic [2:0] a_rd_line, a_wr_line, a_bs;
    logic [5:0] a_q1, a_q2;
    logic b_rd_en, b_rd_comp, b_rd_dir, b_rd_edge, b_wr_en, b_wr_comp, b_wr_dir, b_wr_edge;
    logic b_busy, b_done;
    logic [2:0] b_rd_line, b_wr_line, b_bs;
    logic [5:0] b_q1, b_q2;

    obs_t o0, o1;

    always #5 clk = ~clk;

    chroma_db_ctrl #(.RD_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .disable_all_i(dis),
        .left_en_i(left), .top_en_i(top), .bs_v_i(bsv), .bs_h_i(bsh),
        .qp_cb_cur_i(qcb_cur), .qp_cb_left_i(qcb_left), .qp_cb_top_i(qcb_top),
        .qp_cr_cur_i(qcr_cur), .qp_cr_left_i(qcr_left), .qp_cr_top_i(qcr_top),
        .rd_en(a_rd_en), .rd_comp(a_rd_comp), .rd_dir(a_rd_dir), .rd_edge(a_rd_edge),
        .rd_line(a_rd_line), .pipe_bs_o(a_bs), .pipe_qp1_o(a_q1), .pipe_qp2_o(a_q2),
        .wr_en(a_wr_en), .wr_comp(a_wr_comp), .wr_dir(a_wr_dir), .wr_edge(a_wr_edge),
        .wr_line(a_wr_line), .busy(a_busy), .done(a_done)
    );

    chroma_db_ctrl #(.RD_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .disable_all_i(dis),
        .left_en_i(left), .top_en_i(top), .bs_v_i(bsv), .bs_h_i(bsh),
        .qp_cb_cur_i(qcb_cur), .qp_cb_left_i(qcb_left), .qp_cb_top_i(qcb_top),
        .qp_cr_cur_i(qcr_cur), .qp_cr_left_i(qcr_left), .qp_cr_top_i(qcr_top),
        .rd_en(b_rd_en), .rd_comp(b_rd_comp), .rd_dir(b_rd_dir), .rd_edge(b_rd_edge),
        .rd_line(b_rd_line), .pipe_bs_o(b_bs), .pipe_qp1_o(b_q1), .pipe_qp2_o(b_q2),
        .wr_en(b_wr_en), .wr_comp(b_wr_comp), .wr_dir(b_wr_dir), .wr_edge(b_wr_edge),
        .wr_line(b_wr_line), .busy(b_busy), .done(b_done)
    );

    assign o0 = {a_rd_en, a_rd_comp, a_rd_dir, a_rd_edge, a_rd_line, a_bs, a_q1, a_q2,
                 a_wr_en, a_wr_comp, a_wr_dir, a_wr_edge, a_wr_line, a_busy, a_done};
    assign o1 = {b_rd_en, b_rd_comp, b_rd_dir, b_rd_edge, b_rd_line, b_bs, b_q1, b_q2,
                 b_wr_en, b_wr_comp, b_wr_dir, b_wr_edge, b_wr_line, b_busy, b_done};

    int total = 0;
    int bad   = 0;
    int cur_cyc = 0;

    // Expected read schedule per instance (index 0: RD_LAT=1, 1: RD_LAT=2)
    logic       e_en   [2][NC];
    logic       e_comp [2][NC];
    logic       e_dir  [2][NC];
    logic       e_edge [2][NC];
    logic [2:0] e_line [2][NC];
    logic [2:0] e_bs   [2][NC];
    logic [5:0] e_q1   [2][NC];
    logic [5:0] e_q2   [2][NC];
    int         e_done [2];

    logic [2:0] log_bs0 [NC];
    logic [5:0] log_q10 [NC];
    logic [5:0] log_q20 [NC];
    logic [2:0] log_bs1 [NC];
    logic       log_wr0 [NC];
    logic       log_wr1 [NC];

    vec_t vecs [6];

    task automatic chk(input string name, input int dut, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s rd_lat=%0d cyc=%0d actual=%0d required=%0d",
                     name, dut + 1, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] bs_of(input vec_t v, input int dir, input int e, input int l);
        logic [23:0] b;
        b = (dir != 0) ? v.bsh : v.bsv;
        b = b >> ((e * 4 + l / 2) * 3);
        return b[2:0];
    endfunction

    task automatic build(input vec_t v);
        int c;
        logic [5:0] cur, side;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NC; k++) begin
                e_en[d][k] = 1'b0; e_comp[d][k] = 1'b0; e_dir[d][k] = 1'b0;
                e_edge[d][k] = 1'b0; e_line[d][k] = '0; e_bs[d][k] = '0;
                e_q1[d][k] = '0; e_q2[d][k] = '0;
            end
            c = 1;
            if (v.dis) begin
                e_done[d] = 1;
            end else begin
                for (int comp = 0; comp < 2; comp++) begin
                    for (int dir = 0; dir < 2; dir++) begin
                        cur  = (comp != 0) ? v.cr_cur : v.cb_cur;
                        side = (comp != 0) ? ((dir != 0) ? v.cr_top : v.cr_left)
                                           : ((dir != 0) ? v.cb_top : v.cb_left);
                        for (int e = 0; e < 2; e++) begin
                            if (e == 1 || ((dir != 0) ? v.top : v.left)) begin
                                for (int l = 0; l < 8; l++) begin
                                    e_en[d][c]   = 1'b1;
                                    e_comp[d][c] = 1'(comp);
                                    e_dir[d][c]  = 1'(dir);
                                    e_edge[d][c] = 1'(e);
                                    e_line[d][c] = 3'(l);
                                    e_bs[d][c]   = bs_of(v, dir, e, l);
                                    e_q1[d][c]   = (e == 1) ? cur : side;
                                    e_q2[d][c]   = cur;
                                    c++;
                                end
                            end
                        end
                        if (dir == 0) c += d + 3;
                    end
                end
                c += d + 3;
                e_done[d] = c;
            end
        end
    endtask

    task automatic check_cycle(input int k);
        obs_t o;
        int kr, kw;
        logic vld, wv;
        cur_cyc = k;
        for (int d = 0; d < 2; d++) begin
            o = (d == 0) ? o0 : o1;
            chk("rd_en", d, int'(o.rd_en), int'(e_en[d][k]));
            if (e_en[d][k]) begin
                chk("rd_comp", d, int'(o.rd_comp), int'(e_comp[d][k]));
                chk("rd_dir",  d, int'(o.rd_dir),  int'(e_dir[d][k]));
                chk("rd_edge", d, int'(o.rd_edge), int'(e_edge[d][k]));
                chk("rd_line", d, int'(o.rd_line), int'(e_line[d][k]));
            end
            kr  = k - (d + 1);
            vld = (kr >= 1) && e_en[d][kr];
            chk("pipe_bs", d, int'(o.bs), vld ? int'(e_bs[d][kr]) : 0);
            if (vld) begin
                chk("pipe_qp1", d, int'(o.q1), int'(e_q1[d][kr]));
                chk("pipe_qp2", d, int'(o.q2), int'(e_q2[d][kr]));
            end
            kw = k - (d + 3);
            wv = (kw >= 1) && e_en[d][kw];
            chk("wr_en", d, int'(o.wr_en), int'(wv));
            if (wv) begin
                chk("wr_comp", d, int'(o.wr_comp), int'(e_comp[d][kw]));
                chk("wr_dir",  d, int'(o.wr_dir),  int'(e_dir[d][kw]));
                chk("wr_edge", d, int'(o.wr_edge), int'(e_edge[d][kw]));
                chk("wr_line", d, int'(o.wr_line), int'(e_line[d][kw]));
            end
            chk("busy", d, int'(o.busy), int'(k <= e_done[d]));
            chk("done", d, int'(o.done), int'(k == e_done[d]));
        end
    endtask

    task automatic apply_inputs(input vec_t v);
        dis = v.dis; left = v.left; top = v.top; bsv = v.bsv; bsh = v.bsh;
        qcb_cur = v.cb_cur; qcb_left = v.cb_left; qcb_top = v.cb_top;
        qcr_cur = v.cr_cur; qcr_left = v.cr_left; qcr_top = v.cr_top;
    endtask

    task automatic scramble_inputs();
        dis = 1'($urandom); left = 1'($urandom); top = 1'($urandom);
        bsv = 24'($urandom); bsh = 24'($urandom);
        qcb_cur = 6'($urandom); qcb_left = 6'($urandom); qcb_top = 6'($urandom);
        qcr_cur = 6'($urandom); qcr_left = 6'($urandom); qcr_top = 6'($urandom);
    endtask

    // One macroblock; start is also pulsed while busy and in the done cycle
    task automatic run_mb(input int vi);
        int kmax;
        int rd0, rd1, wr0, wr1, dn0, dn1;
        rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; dn0 = -1; dn1 = -1;
        build(vecs[vi]);
        kmax = e_done[1] + 3;
        @(negedge clk);
        apply_inputs(vecs[vi]);
        start = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            start = ((k == 10) && (10 < e_done[0])) || (k == e_done[0]);
            if (k == 1) scramble_inputs();
            check_cycle(k);
            if (k < NC) begin
                log_bs0[k] = a_bs; log_q10[k] = a_q1; log_q20[k] = a_q2;
                log_bs1[k] = b_bs; log_wr0[k] = a_wr_en; log_wr1[k] = b_wr_en;
            end
            rd0 += int'(a_rd_en); rd1 += int'(b_rd_en);
            wr0 += int'(a_wr_en); wr1 += int'(b_wr_en);
            if (a_done && dn0 < 0) dn0 = k;
            if (b_done && dn1 < 0) dn1 = k;
        end
        start = 1'b0;
        cur_cyc = kmax;
        chk("reads_total",  0, rd0, vecs[vi].exp_reads);
        chk("reads_total",  1, rd1, vecs[vi].exp_reads);
        chk("writes_total", 0, wr0, vecs[vi].exp_reads);
        chk("writes_total", 1, wr1, vecs[vi].exp_reads);
        chk("done_cycle",   0, dn0, vecs[vi].exp_done1);
        chk("done_cycle",   1, dn1, vecs[vi].exp_done2);
    endtask

    initial begin
        int wr_seen, busy_seen;

        //        left  top   dis   bs_v         bs_h         cb cur/left/top  cr cur/left/top rd  d1  d2
        vecs[0] = '{1'b1, 1'b1, 1'b0, 24'o44444444, 24'o44444444, 6'd30, 6'd20, 6'd25, 6'd40, 6'd41, 6'd42, 64, 74, 77};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 24'o44444444, 24'o33333333, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 48, 58, 61};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 24'o56674321, 24'o12345670, 6'd30, 6'd20, 6'd25, 6'd40, 6'd41, 6'd42, 64, 74, 77};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 24'o44444444, 24'o44444444, 6'd30, 6'd20, 6'd25, 6'd40, 6'd41, 6'd42,  0,  1,  1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 24'o01234567, 24'o76543210, 6'd51, 6'd52, 6'd53, 6'd61, 6'd62, 6'd63, 48, 58, 61};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 24'o22222222, 24'o11111111, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  32, 42, 45};

        repeat (2) @(negedge clk);
        cur_cyc = 0;
        chk("reset_outputs", 0, int'(o0), 0);
        chk("reset_outputs", 1, int'(o1), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int vi = 0; vi < 6; vi++) begin
            run_mb(vi);
            if (vi == 2) begin
                // segment mapping and QP selection on Cb vertical edges
                cur_cyc = 2;  chk("seg_line0_bs", 0, int'(log_bs0[2]), 1);
                cur_cyc = 3;  chk("seg_line1_bs", 0, int'(log_bs0[3]), 1);
                cur_cyc = 8;  chk("seg_line6_bs", 0, int'(log_bs0[8]), 4);
                cur_cyc = 9;  chk("seg_line7_bs", 0, int'(log_bs0[9]), 4);
                cur_cyc = 2;  chk("edge0_qp1", 0, int'(log_q10[2]), 20);
                cur_cyc = 2;  chk("edge0_qp2", 0, int'(log_q20[2]), 30);
                cur_cyc = 10; chk("edge1_bs",  0, int'(log_bs0[10]), 7);
                cur_cyc = 10; chk("edge1_qp1", 0, int'(log_q10[10]), 30);
                cur_cyc = 10; chk("edge1_qp2", 0, int'(log_q20[10]), 30);
                cur_cyc = 2;  chk("lat2_bs_not_yet", 1, int'(log_bs1[2]), 0);
                cur_cyc = 3;  chk("lat2_bs_line0",   1, int'(log_bs1[3]), 1);
                cur_cyc = 3;  chk("lat1_wr_not_yet", 0, int'(log_wr0[3]), 0);
                cur_cyc = 4;  chk("lat1_wr_first",   0, int'(log_wr0[4]), 1);
                cur_cyc = 5;  chk("lat2_wr_first",   1, int'(log_wr1[5]), 1);
            end
            repeat (2) @(negedge clk);
        end

        // disable_all: done in cycle 1, fresh start accepted in cycle 2
        @(negedge clk);
        apply_inputs(vecs[3]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur_cyc = 1;
        chk("dis_done_c1", 0, int'(a_done), 1);
        chk("dis_rd_c1",   0, int'(a_rd_en), 0);
        @(negedge clk);
        cur_cyc = 2;
        chk("dis_busy_c2", 0, int'(a_busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur_cyc = 3;
        chk("dis_restart_done", 0, int'(a_done), 1);
        chk("dis_restart_busy", 0, int'(a_busy), 1);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-MB, then a clean rerun
        apply_inputs(vecs[0]);
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        cur_cyc = 30;
        chk("midreset_outputs", 0, int'(o0), 0);
        chk("midreset_outputs", 1, int'(o1), 0);
        @(negedge clk);
        rst = 1'b1;
        wr_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wr_seen += int'(a_wr_en) + int'(b_wr_en);
            busy_seen += int'(a_busy) + int'(b_busy);
        end
        cur_cyc = 41;
        chk("post_reset_wr", 0, wr_seen, 0);
        chk("post_reset_busy", 0, busy_seen, 0);
        run_mb(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
